fetch_align_buffer: RTL



---
 rtl/fetch_align_buffer.sv | 78 +++++++
 1 files changed

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: two-entry word buffer assembling 32-bit fetch windows at halfword granularity (optional FETCH_PREFETCH_EN); ports: clk/rst/inv, core_ren/core_addr -> core_rdata/core_stall, mem_ren/mem_addr <- mem_rdata/mem_stall
module fetch_align_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        inv,
  input  logic        core_ren,
  input  logic [30:0] core_addr,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  output logic        mem_ren,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_stall
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state_q, state_d;
  logic [1:0]  v_q, v_d;
  logic [29:0] tag_q [2];
  logic [29:0] tag_d [2];
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];
  logic [29:0] addr_q, addr_d;
  logic [29:0] a, b;
  logic [31:0] wa, wb;
  logic        hit_a, hit_b, hit;
  always_comb begin
    a = core_addr[30:1];
    b = a + 30'd1;
    hit_a = v_q[a[0]] && tag_q[a[0]] == a;
    hit_b = v_q[b[0]] && tag_q[b[0]] == b;
    hit = core_ren && hit_a && (!core_addr[0] || hit_b);
    wa = data_q[a[0]];
    wb = data_q[b[0]];
    core_rdata = !hit ? '0 : core_addr[0] ? {wa[15:0], wb[31:16]} : wa;
    core_stall = core_ren && !hit;
    mem_ren = state_q == WAIT;
    mem_addr = addr_q;
    state_d = state_q;
    v_d = v_q;
    tag_d = tag_q;
    data_d = data_q;
    addr_d = addr_q;
    if (state_q == IDLE) begin
      if (core_stall) begin
        state_d = WAIT;
        addr_d = hit_a ? b : a;
      end
`ifdef FETCH_PREFETCH_EN
      else if (hit && !core_addr[0] && !hit_b) begin
        state_d = WAIT;
        addr_d = b;
      end
`else
`endif
    end else if (!mem_stall) begin
      state_d = IDLE;
      v_d[addr_q[0]] = 1'b1;
      tag_d[addr_q[0]] = addr_q;
      data_d[addr_q[0]] = mem_rdata;
    end
    if (inv) v_d = '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_q <= '0;
      tag_q <= '{default: '0};
      data_q <= '{default: '0};
      addr_q <= '0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      tag_q <= tag_d;
      data_q <= data_d;
      addr_q <= addr_d;
    end
  end
endmodule
